// File: rtl/wb_burst_master.sv
// Wishbone B3 burst master: single-word and linear incrementing bursts on
// behalf of a start/done client, with a no-ack timeout abort.
module wb_burst_master #(
  parameter int unsigned LEN_BITS = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                req_start,
  input  logic                req_we,
  input  logic [29:0]         req_addr,
  input  logic [LEN_BITS:0]   req_len,
  output logic                req_busy,
  output logic                req_done,
  output logic                req_err,

  input  logic [31:0]         wr_data,
  output logic                wr_pop,
  output logic [31:0]         rd_data,
  output logic                rd_valid,

  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic [29:0]         wbm_addr_o,
  output logic [2:0]          wbm_cti_o,
  output logic [1:0]          wbm_bte_o,
  output logic [3:0]          wbm_sel_o,
  output logic                wbm_we_o,
  output logic [31:0]         wbm_data_o,
  input  logic [31:0]         wbm_data_i,
  input  logic                wbm_ack_i
);

  localparam int unsigned LEN_W = LEN_BITS + 1;
  localparam logic [7:0]  TMO   = 8'(TIMEOUT);
  localparam logic [2:0]  CTI_CLASSIC = 3'b000;
  localparam logic [2:0]  CTI_INC     = 3'b010;
  localparam logic [2:0]  CTI_END     = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_FIN} state_e;

  state_e             state_q;
  logic               cyc_q, stb_q, we_q;
  logic [29:0]        addr_q, addr_d;
  logic [2:0]         cti_q;
  logic               busy_q, done_q, err_q;
  logic [LEN_BITS:0]  len_q, cnt_q, cnt_d;
  logic [7:0]         tmo_q;

  assign addr_d = addr_q + 30'd1;
  assign cnt_d  = cnt_q + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      cti_q   <= CTI_CLASSIC;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_start) begin
            if (req_len != '0) begin
              state_q <= S_BURST;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              we_q    <= req_we;
              addr_q  <= req_addr;
              len_q   <= req_len;
              cnt_q   <= '0;
              tmo_q   <= '0;
              busy_q  <= 1'b1;
              cti_q   <= (req_len == LEN_W'(1)) ? CTI_END : CTI_INC;
            end else begin
              // empty request: immediate completion, never touches the bus
              done_q <= 1'b1;
            end
          end
        end
        S_BURST: begin
          if (wbm_ack_i) begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            tmo_q  <= '0;
            if (cnt_d == len_q) begin
              state_q <= S_FIN;
              cyc_q   <= 1'b0;
              stb_q   <= 1'b0;
              cti_q   <= CTI_CLASSIC;
              done_q  <= 1'b1;
            end else if (cnt_d == len_q - LEN_W'(1)) begin
              cti_q <= CTI_END;
            end
          end else if (tmo_q == TMO) begin
            state_q <= S_FIN;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            cti_q   <= CTI_CLASSIC;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_busy   = busy_q;
  assign req_done   = done_q;
  assign req_err    = err_q;

  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = stb_q;
  assign wbm_addr_o = addr_q;
  assign wbm_cti_o  = cti_q;
  assign wbm_bte_o  = 2'b00;
  assign wbm_sel_o  = 4'hF;
  assign wbm_we_o   = we_q;
  assign wbm_data_o = wr_data;

  assign wr_pop     = cyc_q & stb_q & we_q & wbm_ack_i;
  assign rd_valid   = cyc_q & stb_q & ~we_q & wbm_ack_i;
  assign rd_data    = wbm_data_i;

endmodule

// File: tb/tb_wb_burst_master.sv
// Randomized bench for wb_burst_master: a behavioural slave plus a beat-level
// expectation model (address base+i, cti by beat position, one done per request).
module tb_wb_burst_master;

  localparam int unsigned LEN_BITS = 4;
  localparam int unsigned TIMEOUT  = 255;
  localparam int unsigned LW       = LEN_BITS + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_start, req_we, req_busy, req_done, req_err;
  logic [29:0]       req_addr;
  logic [LEN_BITS:0] req_len;
  logic [31:0]       wr_data, rd_data, wbm_data_o, wbm_data_i;
  logic              wr_pop, rd_valid;
  logic              wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [29:0]       wbm_addr_o;
  logic [2:0]        wbm_cti_o;
  logic [1:0]        wbm_bte_o;
  logic [3:0]        wbm_sel_o;

  always #5 clk = ~clk;

  wb_burst_master #(.LEN_BITS(LEN_BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_start(req_start), .req_we(req_we), .req_addr(req_addr), .req_len(req_len),
    .req_busy(req_busy), .req_done(req_done), .req_err(req_err),
    .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data), .rd_valid(rd_valid),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_addr_o(wbm_addr_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_data_o(wbm_data_o), .wbm_data_i(wbm_data_i),
    .wbm_ack_i(wbm_ack_i)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_pop = 0, n_valid = 0, n_done = 0;

  always @(negedge clk) begin
    if (wr_pop === 1'b1)   n_pop++;
    if (rd_valid === 1'b1) n_valid++;
    if (req_done === 1'b1) n_done++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request. Beat i is expected at base+i (30-bit wrap) with cti 111 on the
  // last beat and 010 before it. rst_at >= 0 applies reset before that beat.
  task automatic do_burst(input logic we, input logic [29:0] base, input int unsigned len,
                          input int unsigned smin, input int unsigned smax,
                          input bit use_seed, input logic [31:0] seed,
                          input bit inject, input int rst_at);
    int unsigned p0, v0, d0, stall;
    logic [29:0] ea;
    logic [2:0]  ecti;
    logic [31:0] wd, rdw;
    p0 = n_pop; v0 = n_valid; d0 = n_done;
    req_we = we; req_addr = base; req_len = LW'(len); req_start = 1'b1;
    tick();
    req_start = 1'b0;
    if (len == 0) begin
      check("len0_done", 32'(req_done), 32'd1);
      check("len0_busy", 32'(req_busy), 32'd0);
      check("len0_cyc", 32'(wbm_cyc_o), 32'd0);
      tick();
      check("len0_done_clr", 32'(req_done), 32'd0);
      check("len0_ndone", n_done - d0, 32'd1);
      return;
    end
    check("start_busy", 32'(req_busy), 32'd1);
    for (int unsigned i = 0; i < len; i++) begin
      if (rst_at >= 0 && i == int'(rst_at)) begin
        rst = 1'b1;
        wbm_ack_i = 1'b0;
        tick();
        rst = 1'b0;
        check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        check("rst_stb", 32'(wbm_stb_o), 32'd0);
        check("rst_busy", 32'(req_busy), 32'd0);
        check("rst_done", 32'(req_done), 32'd0);
        tick();
        check("rst_done2", 32'(req_done), 32'd0);
        check("rst_ndone", n_done - d0, 32'd0);
        check("rst_npop", n_pop - p0, 32'(rst_at));
        return;
      end
      ea   = base + 30'(i);
      ecti = (i == len - 1) ? 3'b111 : 3'b010;
      wd   = use_seed ? seed + 32'(i) : $urandom;
      wr_data = wd;
      stall = $urandom_range(smax, smin);
      for (int unsigned s = 0; s <= stall; s++) begin
        rdw = use_seed ? seed + 32'(i) : $urandom;
        wbm_data_i = rdw;
        wbm_ack_i = (s == stall);
        if (inject && i == 1 && s == stall) begin
          req_start = 1'b1;
          req_addr  = 30'($urandom);
          req_len   = LW'(3);
        end
        #1;
        check("cyc", 32'(wbm_cyc_o), 32'd1);
        check("stb", 32'(wbm_stb_o), 32'd1);
        check("addr", 32'(wbm_addr_o), 32'(ea));
        check("cti", 32'(wbm_cti_o), 32'(ecti));
        check("we", 32'(wbm_we_o), 32'(we));
        check("sel_bte", {26'd0, wbm_sel_o, wbm_bte_o}, 32'h3C);
        check("done_early", 32'({req_done, req_err}), 32'd0);
        if (we) begin
          check("wdata", wbm_data_o, wd);
          check("wr_pop", 32'(wr_pop), 32'(s == stall));
          check("rd_valid_w", 32'(rd_valid), 32'd0);
        end else begin
          check("rd_valid", 32'(rd_valid), 32'(s == stall));
          check("wr_pop_r", 32'(wr_pop), 32'd0);
          if (s == stall) check("rdata", rd_data, rdw);
        end
        tick();
        req_start = 1'b0;
        wbm_ack_i = 1'b0;
      end
    end
    check("fin_cyc", 32'(wbm_cyc_o), 32'd0);
    check("fin_stb", 32'(wbm_stb_o), 32'd0);
    check("fin_cti", 32'(wbm_cti_o), 32'd0);
    check("fin_done", 32'(req_done), 32'd1);
    check("fin_err", 32'(req_err), 32'd0);
    check("fin_busy", 32'(req_busy), 32'd1);
    tick();
    check("idle_done", 32'(req_done), 32'd0);
    check("idle_busy", 32'(req_busy), 32'd0);
    tick();
    tick();
    check("post_cyc", 32'(wbm_cyc_o), 32'd0);
    check("n_pop", n_pop - p0, we ? len : 0);
    check("n_valid", n_valid - v0, we ? 0 : len);
    check("n_done", n_done - d0, 32'd1);
  endtask

  // Read request the slave never acknowledges: the cycle is held for
  // TIMEOUT+1 cycles (counter reaches TIMEOUT, next edge aborts).
  task automatic do_timeout(input logic [29:0] base);
    int unsigned v0, d0, odd;
    v0 = n_valid; d0 = n_done; odd = 0;
    wbm_ack_i = 1'b0;
    req_we = 1'b0; req_addr = base; req_len = LW'(2); req_start = 1'b1;
    tick();
    req_start = 1'b0;
    for (int unsigned k = 1; k <= TIMEOUT; k++) begin
      tick();
      if (wbm_cyc_o !== 1'b1 || req_done !== 1'b0 || wbm_addr_o !== base) odd++;
    end
    check("tmo_hold", odd, 32'd0);
    tick();
    check("tmo_cyc", 32'(wbm_cyc_o), 32'd0);
    check("tmo_stb", 32'(wbm_stb_o), 32'd0);
    check("tmo_done", 32'(req_done), 32'd1);
    check("tmo_err", 32'(req_err), 32'd1);
    tick();
    check("tmo_clr", 32'({req_done, req_err, req_busy}), 32'd0);
    check("tmo_nvalid", n_valid - v0, 32'd0);
    check("tmo_ndone", n_done - d0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_start = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    wr_data = '0; wbm_data_i = '0; wbm_ack_i = 1'b0;
    tick(); tick();
    check("rst_cyc_stb", 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o}), 32'd0);
    check("rst_addr", 32'(wbm_addr_o), 32'd0);
    check("rst_cti", 32'(wbm_cti_o), 32'd0);
    check("rst_status", 32'({req_busy, req_done, req_err}), 32'd0);
    rst = 1'b0;
    tick();

    do_burst(1'b1, 30'h100, 1, 2, 2, 1'b1, 32'hDEADBEEF, 1'b0, -1);
    do_burst(1'b0, 30'h200, 4, 0, 0, 1'b1, 32'h000000A0, 1'b0, -1);
    do_burst(1'b1, 30'h3FFFFFF8, 16, 0, 3, 1'b0, 32'h0, 1'b0, -1);
    do_timeout(30'h1234);
    do_burst(1'b0, 30'h55, 0, 0, 0, 1'b0, 32'h0, 1'b0, -1);
    do_burst(1'b0, 30'h300, 4, 0, 2, 1'b0, 32'h0, 1'b1, -1);
    do_burst(1'b1, 30'h400, 8, 0, 1, 1'b0, 32'h0, 1'b0, 2);
    do_burst(1'b1, 30'h500, 3, 0, 1, 1'b0, 32'h0, 1'b0, -1);
    for (int unsigned r = 0; r < 6; r++)
      do_burst(1'($urandom_range(1, 0)), 30'($urandom), $urandom_range(16, 1),
               0, 3, 1'b0, 32'h0, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
